// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU/MDU opcode encodings and counter sizing helper.
package alu_pkg;
  localparam logic [3:0] ALU_ZERO = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_NOR  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_LUI  = 4'b1100;
  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;
  function automatic int cnt_width(input int m, input int d);
    return $clog2(m > d ? m : d) + 1;
  endfunction
endpackage

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide with pending result, HI/LO and busy.
module md_unit
  import alu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             start,
  input  logic [2:0]       op,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = cnt_width(MULT_CYCLES, DIV_CYCLES);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] pend_hi, pend_lo, q_s, r_s, res_hi, res_lo;
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic pend_wr, accept, is_mul, is_div, ovf;
  assign busy = cnt != '0;
  always_comb begin
    accept = start && !busy;
    is_mul = op == MD_MULT || op == MD_MULTU;
    is_div = op == MD_DIV || op == MD_DIVU;
    ovf    = a == MIN && b == '1;
    prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    q_s    = ovf ? MIN : WIDTH'($signed(a) / $signed(b));
    r_s    = ovf ? '0 : WIDTH'($signed(a) % $signed(b));
    res_hi = op == MD_MULT ? prod_s[2*WIDTH-1:WIDTH] : op == MD_MULTU ? prod_u[2*WIDTH-1:WIDTH] :
             op == MD_DIV ? r_s : a % b;
    res_lo = op == MD_MULT ? prod_s[WIDTH-1:0] : op == MD_MULTU ? prod_u[WIDTH-1:0] :
             op == MD_DIV ? q_s : a / b;
  end
  // the result is captured at acceptance, so operand changes during busy are harmless
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else if (accept && (is_mul || is_div)) begin
      cnt     <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      pend_hi <= res_hi;
      pend_lo <= res_lo;
      pend_wr <= !(is_div && b == '0);
    end else if (accept && op == MD_MTHI) begin
      hi <= a;
    end else if (accept && op == MD_MTLO) begin
      lo <= a;
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1) && pend_wr) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end
  end
endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: combinational execute-stage ALU plus the multi-cycle multiply/divide unit.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_out,
  input  logic             md_start,
  input  logic [2:0]       md_op,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int SW = $clog2(WIDTH);
  logic [SW-1:0] shamt;
  assign shamt = alu_a[SW-1:0];
  always_comb begin
    alu_out = '0;
    case (alu_op)
      ALU_ADD:  alu_out = alu_a + alu_b;
      ALU_SUB:  alu_out = alu_a - alu_b;
      ALU_OR:   alu_out = alu_a | alu_b;
      ALU_AND:  alu_out = alu_a & alu_b;
      ALU_XOR:  alu_out = alu_a ^ alu_b;
      ALU_NOR:  alu_out = ~(alu_a | alu_b);
      ALU_SLT:  alu_out = {{(WIDTH-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_out = {{(WIDTH-1){1'b0}}, alu_a < alu_b};
      ALU_SLL:  alu_out = alu_b << shamt;
      ALU_SRL:  alu_out = alu_b >> shamt;
      ALU_SRA:  alu_out = $signed(alu_b) >>> shamt;
      ALU_LUI:  alu_out = alu_b << (WIDTH/2);
      default:  alu_out = '0;
    endcase
  end
  md_unit #(.WIDTH(WIDTH), .MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_md (
    .clk(clk), .reset(reset), .a(alu_a), .b(alu_b), .start(md_start), .op(md_op),
    .busy(busy), .hi(hi), .lo(lo)
  );
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: scoreboard bench for the ALU and the multiply/divide unit.
module tb_alu_mdu;
  logic clk = 0, reset = 0, md_start = 0, busy;
  logic [31:0] alu_a = 0, alu_b = 0, alu_out, hi, lo;
  logic [3:0] alu_op = 0;
  logic [2:0] md_op = 0;
  int total = 0, bad = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = 0, m_lo = 0;
  always #5 clk = ~clk;
  alu_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .md_start(md_start), .md_op(md_op), .busy(busy), .hi(hi), .lo(lo)
  );
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] cur);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint p = sa * sb;
    case (op)
      3'd0: return p;
      3'd1: return {32'b0, a} * {32'b0, b};
      3'd2: begin
        if (b == 0) return cur;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      3'd3: return b == 0 ? cur : {a % b, a / b};
      default: return cur;
    endcase
  endfunction
  task automatic start(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_op = op; alu_a = a; alu_b = b; md_start = 1;
    if (op < 3'd4) exp_q.push_back(model(op, a, b, {m_hi, m_lo}));
    @(negedge clk);
    md_start = 0;
    if (op == 3'd4) m_hi = a;
    if (op == 3'd5) m_lo = a;
  endtask
  task automatic run_busy(output int cyc, output bit held);
    held = 1; cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      if (hi !== m_hi || lo !== m_lo) held = 0;
      cyc++;
      @(negedge clk);
    end
  endtask
  task automatic md_case(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int n);
    int cyc; bit held; logic [63:0] e;
    start(op, a, b);
    alu_a = ~a; alu_b = b + 1;
    run_busy(cyc, held);
    e = exp_q.pop_front();
    total++; if (cyc !== n) begin bad++; $display("FAIL %s busy cycles got %0d want %0d", name, cyc, n); end
    total++; if (!held) begin bad++; $display("FAIL %s hi/lo changed during busy want %h/%h", name, m_hi, m_lo); end
    total++; if ({hi, lo} !== e) begin bad++; $display("FAIL %s hi/lo got %h/%h want %h/%h", name, hi, lo, e[63:32], e[31:0]); end
    {m_hi, m_lo} = e;
  endtask
  task automatic test_reset;
    md_op = 3'd4; alu_a = 32'h5555; md_start = 1;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got %b want 0", busy); end
    total++; if (hi !== 0) begin bad++; $display("FAIL reset hi got %h want 0", hi); end
    total++; if (lo !== 0) begin bad++; $display("FAIL reset lo got %h want 0", lo); end
    md_start = 0; reset = 1;
  endtask
  task automatic test_alu;
    logic [3:0] ops[15] = '{4'h7, 4'h8, 4'hB, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h9, 4'hA, 4'h9, 4'hC, 4'h0, 4'hD};
    logic [31:0] av[15] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h4, 32'hFFFFFFFF, 32'h0, 32'hF0F0, 32'hFF00FF00,
                            32'hFFFF0000, 32'h0, 32'h4, 32'h18, 32'h21, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bv[15] = '{32'h1, 32'h1, 32'h80000000, 32'h1, 32'h1, 32'h0F0F, 32'h0FF00FF0,
                            32'h0F0F0F0F, 32'h0, 32'h1, 32'h80000000, 32'h1, 32'h1234, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ev[15] = '{32'h1, 32'h0, 32'hF8000000, 32'h0, 32'hFFFFFFFF, 32'hFFFF, 32'h0F000F00,
                            32'hF0F00F0F, 32'hFFFFFFFF, 32'h10, 32'h80, 32'h2, 32'h12340000, 32'h0, 32'h0};
    for (int i = 0; i < 15; i++) begin
      alu_op = ops[i]; alu_a = av[i]; alu_b = bv[i];
      #1;
      total++; if (alu_out !== ev[i]) begin bad++; $display("FAIL alu op=%h got %h want %h", ops[i], alu_out, ev[i]); end
    end
  endtask
  task automatic test_mult;
    @(negedge clk);
    md_case("mult", 3'd0, 32'hFFFFFFF9, 32'h3, 5);
    total++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin bad++; $display("FAIL mult_const got %h/%h want FFFFFFFF/FFFFFFEB", hi, lo); end
    md_case("multu", 3'd1, 32'hFFFFFFF9, 32'h3, 5);
    total++; if ({hi, lo} !== 64'h00000002_FFFFFFEB) begin bad++; $display("FAIL multu_const got %h/%h want 00000002/FFFFFFEB", hi, lo); end
    md_case("mult_rand", 3'd0, $urandom, $urandom, 5);
    md_case("multu_rand", 3'd1, $urandom, $urandom, 5);
  endtask
  task automatic test_div;
    @(negedge clk);
    md_case("div", 3'd2, 32'h7, 32'hFFFFFFFE, 10);
    total++; if ({hi, lo} !== 64'h00000001_FFFFFFFD) begin bad++; $display("FAIL div_const got %h/%h want 00000001/FFFFFFFD", hi, lo); end
    md_case("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 10);
    md_case("div_rand", 3'd2, $urandom, $urandom_range(1, 1000) * 32'd77, 10);
    md_case("divu_rand", 3'd3, $urandom, $urandom_range(1, 65535), 10);
  endtask
  task automatic test_back_to_back;
    int cyc; bit held; logic [63:0] e;
    @(negedge clk);
    start(3'd0, 32'h12345678, 32'h9ABCDEF0);
    @(negedge clk);
    md_op = 3'd5; alu_a = 32'h1234; alu_b = 32'h0; md_start = 1;
    run_busy(cyc, held);
    e = exp_q.pop_front();
    total++; if (cyc !== 4) begin bad++; $display("FAIL b2b remaining busy got %0d want 4", cyc); end
    total++; if (!held) begin bad++; $display("FAIL b2b hi/lo changed during busy want %h/%h", m_hi, m_lo); end
    total++; if ({hi, lo} !== e) begin bad++; $display("FAIL b2b mult got %h/%h want %h/%h", hi, lo, e[63:32], e[31:0]); end
    @(negedge clk);
    md_start = 0;
    total++; if (lo !== 32'h1234 || hi !== e[63:32]) begin bad++; $display("FAIL b2b restart got %h/%h want %h/00001234", hi, lo, e[63:32]); end
    {m_hi, m_lo} = {e[63:32], 32'h1234};
  endtask
  task automatic test_divzero;
    @(negedge clk);
    start(3'd4, 32'h5555, 32'h0);
    total++; if (hi !== 32'h5555 || busy !== 1'b0) begin bad++; $display("FAIL mthi got hi=%h busy=%b want 5555/0", hi, busy); end
    md_case("divu_zero", 3'd3, 32'h9, 32'h0, 10);
    md_case("div_zero", 3'd2, 32'h9, 32'h0, 10);
  endtask
  task automatic test_reset_mid;
    int cyc; bit held; logic [63:0] e;
    @(negedge clk);
    start(3'd2, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    #2 reset = 0;
    #1;
    total++; if (busy !== 0 || hi !== 0 || lo !== 0) begin bad++; $display("FAIL reset_mid got busy=%b hi=%h lo=%h want 0", busy, hi, lo); end
    exp_q.delete(); m_hi = 0; m_lo = 0;
    @(negedge clk);
    reset = 1;
    repeat (12) @(negedge clk);
    total++; if (busy !== 0 || hi !== 0 || lo !== 0) begin bad++; $display("FAIL stale got busy=%b hi=%h lo=%h want 0", busy, hi, lo); end
    md_case("mult_after_reset", 3'd0, 32'd6, 32'd7, 5);
    total++; if (lo !== 32'd42 || hi !== 0) begin bad++; $display("FAIL mult_after_reset_const got %h/%h want 0/0000002a", hi, lo); end
  endtask
  initial begin
    test_reset();
    test_alu();
    test_mult();
    test_div();
    test_back_to_back();
    test_divzero();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
